nonconsec_rep_checker: RTL and testbench
========================================

// Module: nonconsec_rep_checker
// PURPOSE
//  Synthesizable multi-channel checker for "trig |-> ##1 evt[=MIN:MAX] ##1 done" (NONCONSEC)
//  or "trig |-> ##1 evt[->MIN:MAX] ##1 done" (GOTO). Each channel runs one attempt at a time,
//  reports pass/fail pulses with a failure cause, and a shared counter tallies failures.
//  Sits beside DUT handshake logic as an on-chip protocol monitor; also bound in benches.
// PARAMETERS
//  NUM_CH      4   independent checker channels
//  MIN_REP     3   minimum evt count (>=1)
//  MAX_REP     3   maximum evt count (>=MIN_REP)
//  TIMEOUT     16  max ACTIVE cycles per attempt before timeout fail (>=2)
//  MODE        0   0 = NONCONSEC ([=]), 1 = GOTO ([->])
//  CNT_W       16  fail_cnt width
// PORTS
//  clk         in   1            clock, all logic on posedge
//  rst_n       in   1            asynchronous active-low reset
//  en          in   1            global enable; low forces all channels IDLE
//  clr_cnt     in   1            synchronous clear of fail_cnt
//  trig        in   NUM_CH       antecedent (a) per channel
//  evt         in   NUM_CH       repeated event (b) per channel
//  done        in   NUM_CH       completion (c) per channel
//  pass        out  NUM_CH       1-cycle pulse: attempt matched
//  fail        out  NUM_CH       1-cycle pulse: attempt failed
//  fail_cause  out  2*NUM_CH     cause of fail, valid with fail: 1 OVERRUN, 2 MISS, 3 TIMEOUT
//  busy        out  NUM_CH       channel in ACTIVE
//  drop        out  NUM_CH       1-cycle pulse: trig ignored while busy
//  fail_cnt    out  CNT_W        saturating total of fail pulses, all channels
// BEHAVIOUR
//  Reset: all channels IDLE; pass, fail, fail_cause, busy, drop, fail_cnt all 0.
//  Per channel, states IDLE, ACTIVE; registers cnt (0..MAX_REP), hit_q, tmr.
//  IDLE: trig&en -> ACTIVE, cnt=0, hit_q=0, tmr=0. evt in trigger cycle never counted (##1).
//  ACTIVE, each cycle, in priority order:
//   1 ok = NONCONSEC: MIN_REP<=cnt<=MAX_REP (evt of this cycle excluded); GOTO: hit_q.
//     done&ok -> pass, IDLE.
//   2 cnt+evt > MAX_REP -> fail OVERRUN, IDLE.
//   3 GOTO only: hit_q & !done & cnt==MAX_REP -> fail MISS, IDLE. (cnt<MAX: keep waiting.)
//   4 tmr==TIMEOUT-1 -> fail TIMEOUT, IDLE.
//   5 else cnt+=evt; hit_q = evt & (MIN_REP<=cnt+1<=MAX_REP); tmr++.
//  done before range reached is ignored (not a fail). NONCONSEC passes on any later done
//  while cnt in range; evt in the done cycle is not counted.
//  Latency: pass/fail/fail_cause registered, asserted the cycle after the deciding cycle.
//  trig while ACTIVE and channel not terminating this cycle -> drop pulse, no new attempt.
//  trig in the cycle an attempt terminates -> new attempt starts (back-to-back ACTIVE).
//  en low: ACTIVE channels go IDLE next edge, no pass/fail/drop; fail_cnt holds.
//  fail_cnt += popcount(fail) each cycle, saturating at all-ones; clr_cnt wins over increment.
//  Reset mid-attempt: abandons attempt silently, no fail pulse.
// STRUCTURE
//  rep_chk_pkg: state_e {IDLE, ACTIVE}; cause_e {NONE, OVERRUN, MISS, TIMEOUT}; mode_e.
//  Sub-module rep_chk_chan: one channel FSM (counter, hit_q, timer, outputs), generated
//  NUM_CH times; top holds fail_cnt popcount/saturation and enable fan-out.
//  cnt width $clog2(MAX_REP+1); tmr width $clog2(TIMEOUT).
// TESTING (cycle numbers relative to trig at cycle 0, defaults unless stated)
//  NONCONSEC: evt at 2,4,6, done at 9 -> pass at 10; repeat with done at 7 -> pass at 8.
//  NONCONSEC: evt at 2,4,6,8, done at 9 -> fail OVERRUN at 9, no pass.
//  MODE=1: evt 2,4,6, done 7 -> pass at 8; done at 8 instead -> fail MISS at 8.
//  MODE=0, MIN=2 MAX=4, evt 1,3 only -> fail TIMEOUT at 17; fail_cnt=1.
//  trig at 0 and 3 -> drop at 4; trig at pass-decision cycle -> busy stays 1, new attempt.
//  en low at 5 mid-attempt -> busy 0 at 6, no fail; rst_n low mid-attempt -> all outputs 0.

Source files
------------

// File: rtl/rep_chk_pkg.sv
// Shared types for the repetition checker: channel FSM states, failure causes and
// checking mode.
package rep_chk_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_OVERRUN = 2'd1,
      CAUSE_MISS    = 2'd2,
      CAUSE_TIMEOUT = 2'd3
   } cause_e;

   typedef enum logic {
      MODE_NONCONSEC = 1'b0,
      MODE_GOTO      = 1'b1
   } mode_e;

endpackage

// File: rtl/rep_chk_chan.sv
// One checker channel: a single attempt of "trig |-> ##1 evt[=/->MIN:MAX] ##1 done"
// with registered pass/fail/drop pulses.
module rep_chk_chan
   import rep_chk_pkg::*;
#(
   parameter int MIN_REP = 3,
   parameter int MAX_REP = 3,
   parameter int TIMEOUT = 16,
   parameter int MODE    = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       trig,
   input  logic       evt,
   input  logic       done,
   output logic       pass,
   output logic       fail,
   output logic [1:0] fail_cause,
   output logic       busy,
   output logic       drop
);

   localparam int CW = $clog2(MAX_REP + 1);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [CW:0]   MIN_V    = (CW+1)'(MIN_REP);
   localparam logic [CW:0]   MAX_V    = (CW+1)'(MAX_REP);
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
   localparam bit            IS_GOTO  = (MODE == int'(MODE_GOTO));

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            hit_q, hit_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            pass_q, pass_d, fail_q, fail_d, drop_q, drop_d;
   cause_e          cause_q, cause_d;

   logic [CW:0]     cnt_cur, cnt_p;
   logic            ok, term;

   assign cnt_cur = {1'b0, cnt_q};
   assign cnt_p   = cnt_cur + {{CW{1'b0}}, evt};
   assign ok      = IS_GOTO ? hit_q : ((cnt_cur >= MIN_V) && (cnt_cur <= MAX_V));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hit_d   = hit_q;
      tmr_d   = tmr_q;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      drop_d  = 1'b0;
      cause_d = CAUSE_NONE;
      term    = 1'b0;
      if (!en) begin
         state_d = ST_IDLE;
      end else if (state_q == ST_IDLE) begin
         if (trig) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
            hit_d   = 1'b0;
            tmr_d   = '0;
         end
      end else begin
         term = 1'b1;
         if (done && ok) begin
            pass_d = 1'b1;
         end else if (cnt_p > MAX_V) begin
            fail_d  = 1'b1;
            cause_d = CAUSE_OVERRUN;
         end else if (IS_GOTO && hit_q && !done && (cnt_cur == MAX_V)) begin
            fail_d  = 1'b1;
            cause_d = CAUSE_MISS;
         end else if (tmr_q == TMR_LAST) begin
            fail_d  = 1'b1;
            cause_d = CAUSE_TIMEOUT;
         end else begin
            term  = 1'b0;
            cnt_d = cnt_p[CW-1:0];
            hit_d = evt && (cnt_p >= MIN_V) && (cnt_p <= MAX_V);
            tmr_d = tmr_q + TW'(1);
         end
         // A trigger coinciding with termination restarts immediately.
         if (term) begin
            state_d = trig ? ST_ACTIVE : ST_IDLE;
            cnt_d   = '0;
            hit_d   = 1'b0;
            tmr_d   = '0;
         end else if (trig) begin
            drop_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hit_q   <= 1'b0;
         tmr_q   <= '0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         drop_q  <= 1'b0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hit_q   <= hit_d;
         tmr_q   <= tmr_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         drop_q  <= drop_d;
         cause_q <= cause_d;
      end
   end

   assign pass       = pass_q;
   assign fail       = fail_q;
   assign fail_cause = cause_q;
   assign drop       = drop_q;
   assign busy       = (state_q == ST_ACTIVE);

endmodule

// File: rtl/nonconsec_rep_checker.sv
// Multi-channel repetition checker: NUM_CH independent channels plus a shared,
// saturating count of failure pulses.
module nonconsec_rep_checker
   import rep_chk_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int MIN_REP = 3,
   parameter int MAX_REP = 3,
   parameter int TIMEOUT = 16,
   parameter int MODE    = 0,
   parameter int CNT_W   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                clr_cnt,
   input  logic [NUM_CH-1:0]   trig,
   input  logic [NUM_CH-1:0]   evt,
   input  logic [NUM_CH-1:0]   done,
   output logic [NUM_CH-1:0]   pass,
   output logic [NUM_CH-1:0]   fail,
   output logic [2*NUM_CH-1:0] fail_cause,
   output logic [NUM_CH-1:0]   busy,
   output logic [NUM_CH-1:0]   drop,
   output logic [CNT_W-1:0]    fail_cnt
);

   localparam int PCW = $clog2(NUM_CH + 1);

   logic [PCW-1:0]   fail_pop;
   logic [CNT_W:0]   cnt_sum;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
         rep_chk_chan #(
            .MIN_REP (MIN_REP),
            .MAX_REP (MAX_REP),
            .TIMEOUT (TIMEOUT),
            .MODE    (MODE)
         ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .trig       (trig[gi]),
            .evt        (evt[gi]),
            .done       (done[gi]),
            .pass       (pass[gi]),
            .fail       (fail[gi]),
            .fail_cause (fail_cause[2*gi +: 2]),
            .busy       (busy[gi]),
            .drop       (drop[gi])
         );
      end
   endgenerate

   always_comb begin
      fail_pop = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         fail_pop = fail_pop + PCW'(fail[i]);
      end
   end

   // One spare bit catches the carry so the counter sticks at all-ones.
   assign cnt_sum = {1'b0, fail_cnt_q} + (CNT_W+1)'(fail_pop);

   always_comb begin
      if (clr_cnt)
         fail_cnt_d = '0;
      else if (cnt_sum[CNT_W])
         fail_cnt_d = '1;
      else
         fail_cnt_d = cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fail_cnt_q <= '0;
      else
         fail_cnt_q <= fail_cnt_d;
   end

   assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_nonconsec_rep_checker.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor pops and compares
// every pass/fail/drop pulse from a NONCONSEC and a GOTO instance.
module tb_nonconsec_rep_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic       clr_cnt = 1'b0;
   logic [3:0] trig_a = '0, evt_a = '0, done_a = '0;
   logic [3:0] trig_g = '0, evt_g = '0, done_g = '0;
   logic [3:0] pass_a, fail_a, busy_a, drop_a;
   logic [3:0] pass_g, fail_g, busy_g, drop_g;
   logic [7:0] cause_a, cause_g;
   logic [15:0] cnt_a, cnt_g;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      int cyc;
      int g;
      int ch;
      int kind;   // 1 pass, 2 fail, 3 drop
      int cause;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nonconsec_rep_checker #(.MODE(0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt),
      .trig(trig_a), .evt(evt_a), .done(done_a),
      .pass(pass_a), .fail(fail_a), .fail_cause(cause_a),
      .busy(busy_a), .drop(drop_a), .fail_cnt(cnt_a)
   );

   nonconsec_rep_checker #(.MODE(1)) u_dut_g (
      .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt),
      .trig(trig_g), .evt(evt_g), .done(done_g),
      .pass(pass_g), .fail(fail_g), .fail_cause(cause_g),
      .busy(busy_g), .drop(drop_g), .fail_cnt(cnt_g)
   );

   // Monitor
   logic [3:0] m_p, m_f, m_d;
   logic [7:0] m_c;
   always @(negedge clk) begin
      if (rst_n) begin
         for (int g = 0; g < 2; g++) begin
            m_p = g ? pass_g : pass_a;
            m_f = g ? fail_g : fail_a;
            m_d = g ? drop_g : drop_a;
            m_c = g ? cause_g : cause_a;
            for (int ch = 0; ch < 4; ch++) begin
               for (int k = 1; k <= 3; k++) begin
                  logic obs;
                  int   cs;
                  exp_t e;
                  obs = (k == 1) ? m_p[ch] : (k == 2) ? m_f[ch] : m_d[ch];
                  cs  = int'(m_c[2*ch +: 2]);
                  if (obs) begin
                     checks++;
                     if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_pulse cyc=%0d inst=%0d ch=%0d kind=%0d cause=%0d, required none",
                                 cyc, g, ch, k, cs);
                     end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || e.g != g || e.ch != ch || e.kind != k ||
                            (k == 2 && e.cause != cs)) begin
                           failures++;
                           $display("FAIL pulse_mismatch actual cyc=%0d inst=%0d ch=%0d kind=%0d cause=%0d required cyc=%0d inst=%0d ch=%0d kind=%0d cause=%0d",
                                    cyc, g, ch, k, cs, e.cyc, e.g, e.ch, e.kind, e.cause);
                        end else begin
                           $display("pulse ok cyc=%0d inst=%0d ch=%0d kind=%0d cause=%0d", cyc, g, ch, k, cs);
                        end
                     end
                  end
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end else begin
         $display("check ok %s value=%0h", name, act);
      end
   endtask

   task automatic push(input int c, input int g, input int ch, input int k, input int cs);
      exp_t e;
      e.cyc = c; e.g = g; e.ch = ch; e.kind = k; e.cause = cs;
      exp_q.push_back(e);
   endtask

   // Called at #1 after a posedge; offset k of each mask is cycle base+k.
   task automatic run_vec(input int g, input int ch,
                          input logic [31:0] tm, input logic [31:0] em,
                          input logic [31:0] dm, input logic [31:0] enm, input int len,
                          input int k0, input int o0, input int c0,
                          input int k1, input int o1, input int c1,
                          input int bsy_off, input logic bsy_req);
      int base;
      base = cyc;
      if (k0 != 0) push(base + o0, g, ch, k0, c0);
      if (k1 != 0) push(base + o1, g, ch, k1, c1);
      for (int k = 0; k < len; k++) begin
         trig_a = '0; evt_a = '0; done_a = '0;
         trig_g = '0; evt_g = '0; done_g = '0;
         en = enm[k];
         if (g == 1) begin
            trig_g[ch] = tm[k]; evt_g[ch] = em[k]; done_g[ch] = dm[k];
         end else begin
            trig_a[ch] = tm[k]; evt_a[ch] = em[k]; done_a[ch] = dm[k];
         end
         if (k == bsy_off)
            check($sformatf("busy_inst%0d_ch%0d_off%0d", g, ch, k),
                  32'(g == 1 ? busy_g[ch] : busy_a[ch]), 32'(bsy_req));
         @(posedge clk); #1;
      end
      trig_a = '0; evt_a = '0; done_a = '0;
      trig_g = '0; evt_g = '0; done_g = '0;
      en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      check("reset_outputs", {pass_a, fail_a, busy_a, drop_a, cause_a, cnt_a[7:0]}, 32'h0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // NONCONSEC: evt 2,4,6; done 9 -> pass 10; done 7 -> pass 8
      run_vec(0, 0, 32'h1, 32'h54, 32'h200, '1, 12, 1, 10, 0, 0, 0, 0, 1, 1'b1);
      run_vec(0, 1, 32'h1, 32'h54, 32'h80,  '1, 10, 1, 8, 0, 0, 0, 0, -1, 1'b0);
      // NONCONSEC overrun: evt 2,4,6,8 -> fail OVERRUN at 9
      run_vec(0, 2, 32'h1, 32'h154, 32'h200, '1, 12, 2, 9, 1, 0, 0, 0, -1, 1'b0);
      // GOTO: done 7 -> pass 8; done 8 -> fail MISS at 8
      run_vec(1, 0, 32'h1, 32'h54, 32'h80,  '1, 10, 1, 8, 0, 0, 0, 0, -1, 1'b0);
      run_vec(1, 1, 32'h1, 32'h54, 32'h100, '1, 10, 2, 8, 2, 0, 0, 0, -1, 1'b0);

      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      check("fail_cnt_after_clr", 32'(cnt_a), 32'd0);
      // Timeout: evt 1,3 only -> fail TIMEOUT at 17
      run_vec(0, 3, 32'h1, 32'h0A, 32'h0, '1, 19, 2, 17, 3, 0, 0, 0, -1, 1'b0);
      check("fail_cnt_after_timeout", 32'(cnt_a), 32'd1);

      // trig at 0 and 3 -> drop at 4, attempt still passes at 8
      run_vec(0, 0, 32'h9, 32'h54, 32'h80, '1, 10, 3, 4, 0, 1, 8, 0, -1, 1'b0);
      // trig on the pass-decision cycle starts a new attempt back-to-back
      run_vec(0, 1, 32'h81, 32'h2A54, 32'h4080, '1, 17, 1, 8, 0, 1, 15, 0, 8, 1'b1);
      // en low at 5 -> busy 0 at 6, no fail ever
      run_vec(0, 2, 32'h1, 32'h14, 32'h0, ~32'h20, 25, 0, 0, 0, 0, 0, 0, 6, 1'b0);

      // Asynchronous reset mid-attempt
      trig_a[3] = 1'b1;
      @(posedge clk); #1;
      trig_a[3] = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_outputs", {pass_a, fail_a, busy_a, drop_a, cause_a, cnt_a[7:0]}, 32'h0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("expected_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
